// File: rtl/sar_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sar_seq_pkg                                                        |
// | Brief  : Shared types, constants and width helpers for the SAR sequencer.   |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
package sar_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRACK   = 3'd1,
    ST_START   = 3'd2,
    ST_CONV    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  // Cycles the ADC reset pin is held high after a timed-out conversion.
  localparam int RECOVER_CYCLES = 2;

  // Bits needed to index n items (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sar_seq_if                                                         |
// | Brief  : Requester, response and sar_logic pin bundle of the sequencer.     |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
interface sar_seq_if #(
  parameter int NREQ = 4
);
  import sar_seq_pkg::*;

  localparam int IDW = idx_w(NREQ);

  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [7:0]      rsp_data;
  logic            rsp_err;
  logic            adc_cnvst;
  logic            adc_rst;
  logic            adc_eoc;
  logic [7:0]      adc_sar;

  // The sequencer side.
  modport slave (
    input  req_valid, rsp_ready, adc_eoc, adc_sar,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, adc_cnvst, adc_rst
  );

  // Requesters, consumer and ADC core side.
  modport master (
    output req_valid, rsp_ready, adc_eoc, adc_sar,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, adc_cnvst, adc_rst
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arbiter                                                         |
// | Brief  : Combinational round-robin pick: first request at/after pointer.    |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  // Walk the request vector starting at the pointer, wrapping, and keep the first hit.
  always_comb begin
    logic [IDW-1:0] pos;
    logic           found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[pos]) begin
        found        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = pos;
      end
    end
    any_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/sar_conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sar_conv_sequencer                                                 |
// | Brief  : Shares one sar_logic ADC among NREQ requesters; round-robin grant, |
// |          settle, cnvst pulse, eoc timeout, averaging, valid/ready result.   |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module sar_conv_sequencer
  import sar_seq_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 3,
  parameter int TIMEOUT  = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  sar_seq_if.slave bus
);

  localparam int IDW  = idx_w(NREQ);
  localparam int ACCW = 8 + AVG_LOG2;
  localparam int CNTW = AVG_LOG2 + 1;
  localparam int TMRW = cnt_w(max_i(max_i(SETTLE, TIMEOUT), RECOVER_CYCLES));

  localparam logic [CNTW-1:0] LAST_SAMPLE  = CNTW'((1 << AVG_LOG2) - 1);
  localparam logic [TMRW-1:0] SETTLE_LAST  = TMRW'(SETTLE - 1);
  localparam logic [TMRW-1:0] TIMEOUT_LAST = TMRW'(TIMEOUT - 1);
  localparam logic [TMRW-1:0] RECOVER_LAST = TMRW'(RECOVER_CYCLES - 1);
  localparam logic [IDW-1:0]  ID_LAST      = IDW'(NREQ - 1);

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [TMRW-1:0] timer_q;      // settle, eoc-timeout and recover counter
  logic [CNTW-1:0] cnt_q;        // conversions completed for this request
  logic [ACCW-1:0] acc_q;
  logic [NREQ-1:0] req_ready_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [7:0]      rsp_data_q;
  logic            rsp_err_q;
  logic            adc_cnvst_q;
  logic            adc_rst_q;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic [ACCW-1:0] acc_sum;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // Accumulator width leaves AVG_LOG2 bits of headroom, so this sum cannot wrap.
  assign acc_sum = acc_q + ACCW'(bus.adc_sar);

  // Sequencer FSM; every output is a register written on the transition into its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      timer_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      adc_cnvst_q <= 1'b0;
      adc_rst_q   <= 1'b1;
    end else begin
      req_ready_q <= '0;
      adc_cnvst_q <= 1'b0;
      adc_rst_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            req_ready_q <= arb_grant;
            rsp_id_q    <= arb_idx;
            acc_q       <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            state_q     <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (timer_q == SETTLE_LAST) begin
            adc_cnvst_q <= 1'b1;   // high for the single START cycle
            state_q     <= ST_START;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_START: begin
          timer_q <= '0;
          state_q <= ST_CONV;
        end
        ST_CONV: begin
          // eoc is checked first so it wins over a coincident timeout
          if (bus.adc_eoc) begin
            acc_q   <= acc_sum;
            cnt_q   <= cnt_q + 1'b1;
            timer_q <= '0;
            if (cnt_q == LAST_SAMPLE) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= 8'(acc_sum >> AVG_LOG2);
              state_q     <= ST_RESP;
            end else begin
              state_q <= ST_TRACK;
            end
          end else if (timer_q == TIMEOUT_LAST) begin
            timer_q   <= '0;
            adc_rst_q <= 1'b1;
            state_q   <= ST_RECOVER;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (timer_q == RECOVER_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            state_q     <= ST_RESP;
          end else begin
            adc_rst_q <= 1'b1;
            timer_q   <= timer_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ptr_q       <= (rsp_id_q == ID_LAST) ? '0 : rsp_id_q + 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.adc_cnvst = adc_cnvst_q;
  assign bus.adc_rst   = adc_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_sar_conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sar_conv_sequencer                                              |
// | Brief  : Directed bench with a sar_logic model (eoc 14 cycles after cnvst). |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_sar_conv_sequencer;

  localparam int NREQ     = 4;
  localparam int E_LAT    = 14;
  localparam int SETTLE   = 3;
  localparam int CONV_CYC = 18;   // SETTLE + 1 + E_LAT

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sar_seq_if #(.NREQ(NREQ)) if_a ();
  sar_seq_if #(.NREQ(NREQ)) if_b ();

  sar_conv_sequencer #(.NREQ(NREQ), .AVG_LOG2(0), .SETTLE(SETTLE), .TIMEOUT(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  sar_conv_sequencer #(.NREQ(NREQ), .AVG_LOG2(2), .SETTLE(SETTLE), .TIMEOUT(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  // ADC model for dut_a: one fixed result.
  logic [7:0] a_sar_val = 8'h00;
  int a_cd = 0;
  int a_cnv_cnt = 0;
  always @(negedge clk) begin
    if_a.adc_eoc = 1'b0;
    if (a_cd > 0) begin
      a_cd = a_cd - 1;
      if (a_cd == 0) begin
        if_a.adc_eoc = 1'b1;
        if_a.adc_sar = a_sar_val;
      end
    end
    if (if_a.adc_rst) a_cd = 0;
    if (if_a.adc_cnvst) begin
      a_cd = E_LAT;
      a_cnv_cnt = a_cnv_cnt + 1;
    end
  end

  // ADC model for dut_b: results from a script queue; also logs cnvst and grants.
  logic [7:0]      b_script [$];
  bit              b_eoc_en = 1'b1;
  int              b_cd = 0;
  int              b_cnv_cyc [$];
  int              b_gnt_cnt = 0;
  logic [NREQ-1:0] b_last_gnt = '0;
  always @(negedge clk) begin
    if_b.adc_eoc = 1'b0;
    if (b_cd > 0) begin
      b_cd = b_cd - 1;
      if (b_cd == 0 && b_eoc_en) begin
        if_b.adc_eoc = 1'b1;
        if (b_script.size() > 0) if_b.adc_sar = b_script.pop_front();
        else                     if_b.adc_sar = 8'h00;
      end
    end
    if (if_b.adc_rst) b_cd = 0;
    if (if_b.adc_cnvst) begin
      b_cd = E_LAT;
      b_cnv_cyc.push_back(cyc);
    end
    if (if_b.req_ready != '0) begin
      b_gnt_cnt  = b_gnt_cnt + 1;
      b_last_gnt = if_b.req_ready;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_b_rsp(input int lim);
    int n = 0;
    while (!if_b.rsp_valid && n < lim) begin step(); n++; end
  endtask

  task automatic wait_b_grant(input int lim);
    int n = 0;
    step();
    while (if_b.req_ready == '0 && n < lim) begin step(); n++; end
  endtask

  task automatic accept_b();
    if_b.rsp_ready = 1'b1;
    step();
    if_b.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (if_b.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", if_b.req_ready); end
    checks++; if (if_b.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", if_b.rsp_valid); end
    checks++; if (if_b.rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", if_b.rsp_id); end
    checks++; if (if_b.rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%0h exp=0", if_b.rsp_data); end
    checks++; if (if_b.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", if_b.rsp_err); end
    checks++; if (if_b.adc_cnvst !== 1'b0) begin failures++; $display("FAIL reset_cnvst got=%b exp=0", if_b.adc_cnvst); end
    checks++; if (if_b.adc_rst !== 1'b1) begin failures++; $display("FAIL reset_adc_rst got=%b exp=1", if_b.adc_rst); end
    checks++; if (if_a.adc_rst !== 1'b1) begin failures++; $display("FAIL reset_adc_rst_a got=%b exp=1", if_a.adc_rst); end
    rst_n = 1'b1;
    step();
    checks++; if (if_b.adc_rst !== 1'b0) begin failures++; $display("FAIL release_adc_rst got=%b exp=0", if_b.adc_rst); end
  endtask

  task automatic test_single();
    int n0, gcyc, n;
    a_sar_val = 8'hA5;
    n0 = a_cnv_cnt;
    if_a.req_valid = 4'b0001;
    n = 0;
    step();
    while (if_a.req_ready == '0 && n < 10) begin step(); n++; end
    checks++; if (if_a.req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", if_a.req_ready); end
    gcyc = cyc;
    if_a.req_valid = 4'b0000;
    n = 0;
    while (!if_a.rsp_valid && n < 100) begin step(); n++; end
    checks++; if ((cyc - gcyc) !== CONV_CYC) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", cyc - gcyc, CONV_CYC); end
    checks++; if (if_a.rsp_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", if_a.rsp_id); end
    checks++; if (if_a.rsp_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%0h exp=a5", if_a.rsp_data); end
    checks++; if (if_a.rsp_err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", if_a.rsp_err); end
    checks++; if ((a_cnv_cnt - n0) !== 1) begin failures++; $display("FAIL single_cnvst_count got=%0d exp=1", a_cnv_cnt - n0); end
    if_a.rsp_ready = 1'b1;
    step();
    if_a.rsp_ready = 1'b0;
    checks++; if (if_a.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_accept got=%b exp=0", if_a.rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [4];
    logic [7:0] exp_data [4];
    int g0;
    exp_id   = '{2'd0, 2'd1, 2'd3, 2'd0};
    exp_data = '{8'd4, 8'd16, 8'd28, 8'd40};
    for (int i = 0; i < 16; i++) b_script.push_back(8'(i * 3));
    g0 = b_gnt_cnt;
    if_b.req_valid = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_b_rsp(200);
      checks++; if (if_b.rsp_valid !== 1'b1) begin failures++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=1", k, if_b.rsp_valid); end
      checks++; if (if_b.rsp_id !== exp_id[k]) begin failures++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, if_b.rsp_id, exp_id[k]); end
      checks++; if (if_b.rsp_data !== exp_data[k]) begin failures++; $display("FAIL rr_data[%0d] got=%0d exp=%0d", k, if_b.rsp_data, exp_data[k]); end
      checks++; if (b_last_gnt !== (4'b0001 << exp_id[k])) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, b_last_gnt, 4'b0001 << exp_id[k]); end
      if (k == 3) if_b.req_valid = 4'b0000;
      accept_b();
    end
    checks++; if ((b_gnt_cnt - g0) !== 4) begin failures++; $display("FAIL rr_grant_count got=%0d exp=4", b_gnt_cnt - g0); end
  endtask

  task automatic test_average();
    int gcyc, q0;
    b_script.push_back(8'd10); b_script.push_back(8'd11);
    b_script.push_back(8'd12); b_script.push_back(8'd14);
    q0 = b_cnv_cyc.size();
    if_b.req_valid = 4'b0100;
    wait_b_grant(10);
    gcyc = cyc;
    if_b.req_valid = 4'b0000;
    wait_b_rsp(200);
    checks++; if ((cyc - gcyc) !== 4 * CONV_CYC) begin failures++; $display("FAIL avg_latency got=%0d exp=%0d", cyc - gcyc, 4 * CONV_CYC); end
    checks++; if (if_b.rsp_data !== 8'd11) begin failures++; $display("FAIL avg_data got=%0d exp=11", if_b.rsp_data); end
    checks++; if (if_b.rsp_id !== 2'd2) begin failures++; $display("FAIL avg_id got=%0d exp=2", if_b.rsp_id); end
    checks++; if (if_b.rsp_err !== 1'b0) begin failures++; $display("FAIL avg_err got=%b exp=0", if_b.rsp_err); end
    checks++; if ((b_cnv_cyc.size() - q0) !== 4) begin failures++; $display("FAIL avg_cnvst_count got=%0d exp=4", b_cnv_cyc.size() - q0); end
    if (b_cnv_cyc.size() >= q0 + 4) begin
      for (int j = 1; j < 4; j++) begin
        checks++;
        if ((b_cnv_cyc[q0+j] - b_cnv_cyc[q0+j-1]) !== CONV_CYC) begin
          failures++; $display("FAIL avg_cnvst_gap[%0d] got=%0d exp=%0d", j, b_cnv_cyc[q0+j] - b_cnv_cyc[q0+j-1], CONV_CYC);
        end
      end
    end
    accept_b();
  endtask

  task automatic test_timeout();
    int q0, ccyc, rcnt, n;
    b_eoc_en = 1'b0;
    q0 = b_cnv_cyc.size();
    if_b.req_valid = 4'b0010;
    wait_b_grant(10);
    if_b.req_valid = 4'b0000;
    n = 0;
    while (!if_b.adc_rst && n < 80) begin step(); n++; end
    ccyc = (b_cnv_cyc.size() > q0) ? b_cnv_cyc[q0] : 0;
    checks++; if ((cyc - ccyc) !== 33) begin failures++; $display("FAIL to_rst_delay got=%0d exp=33", cyc - ccyc); end
    rcnt = 0;
    while (if_b.adc_rst && rcnt < 10) begin rcnt++; step(); end
    checks++; if (rcnt !== 2) begin failures++; $display("FAIL to_rst_cycles got=%0d exp=2", rcnt); end
    checks++; if (if_b.rsp_valid !== 1'b1) begin failures++; $display("FAIL to_rsp_valid got=%b exp=1", if_b.rsp_valid); end
    checks++; if (if_b.rsp_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", if_b.rsp_err); end
    checks++; if (if_b.rsp_data !== 8'h00) begin failures++; $display("FAIL to_data got=%0h exp=0", if_b.rsp_data); end
    checks++; if (if_b.rsp_id !== 2'd1) begin failures++; $display("FAIL to_id got=%0d exp=1", if_b.rsp_id); end
    checks++; if ((b_cnv_cyc.size() - q0) !== 1) begin failures++; $display("FAIL to_cnvst_count got=%0d exp=1", b_cnv_cyc.size() - q0); end
    accept_b();
    checks++; if (if_b.rsp_err !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", if_b.rsp_err); end
    b_eoc_en = 1'b1;
  endtask

  task automatic test_stall();
    int g0, q0, stable;
    logic [1:0] sid;
    logic [7:0] sdata;
    b_script.push_back(8'd100); b_script.push_back(8'd100);
    b_script.push_back(8'd100); b_script.push_back(8'd104);
    b_script.push_back(8'd200); b_script.push_back(8'd201);
    b_script.push_back(8'd202); b_script.push_back(8'd203);
    if_b.req_valid = 4'b0001;
    wait_b_grant(10);
    if_b.req_valid = 4'b0000;
    wait_b_rsp(200);
    if_b.req_valid = 4'b1000;
    sid = if_b.rsp_id; sdata = if_b.rsp_data;
    g0 = b_gnt_cnt; q0 = b_cnv_cyc.size();
    stable = 0;
    repeat (10) begin
      step();
      if (if_b.rsp_valid && if_b.rsp_id == sid && if_b.rsp_data == sdata) stable++;
    end
    checks++; if (stable !== 10) begin failures++; $display("FAIL stall_stable got=%0d exp=10", stable); end
    checks++; if (sdata !== 8'd101) begin failures++; $display("FAIL stall_data got=%0d exp=101", sdata); end
    checks++; if (sid !== 2'd0) begin failures++; $display("FAIL stall_id got=%0d exp=0", sid); end
    checks++; if ((b_gnt_cnt - g0) !== 0) begin failures++; $display("FAIL stall_no_grant got=%0d exp=0", b_gnt_cnt - g0); end
    checks++; if ((b_cnv_cyc.size() - q0) !== 0) begin failures++; $display("FAIL stall_no_cnvst got=%0d exp=0", b_cnv_cyc.size() - q0); end
    accept_b();
    wait_b_grant(10);
    checks++; if (if_b.req_ready !== 4'b1000) begin failures++; $display("FAIL stall_next_grant got=%b exp=1000", if_b.req_ready); end
    if_b.req_valid = 4'b0000;
    wait_b_rsp(200);
    checks++; if (if_b.rsp_id !== 2'd3) begin failures++; $display("FAIL stall_next_id got=%0d exp=3", if_b.rsp_id); end
    checks++; if (if_b.rsp_data !== 8'd201) begin failures++; $display("FAIL stall_next_data got=%0d exp=201", if_b.rsp_data); end
    accept_b();
  endtask

  task automatic test_reset_mid();
    int q0, n, seen;
    q0 = b_cnv_cyc.size();
    if_b.req_valid = 4'b0100;
    wait_b_grant(10);
    if_b.req_valid = 4'b0000;
    n = 0;
    while (b_cnv_cyc.size() == q0 && n < 20) begin step(); n++; end
    repeat (5) step();
    rst_n = 1'b0;
    step();
    checks++; if (if_b.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid got=%b exp=0", if_b.rsp_valid); end
    checks++; if (if_b.req_ready !== 4'b0000) begin failures++; $display("FAIL mid_req_ready got=%b exp=0000", if_b.req_ready); end
    checks++; if (if_b.adc_cnvst !== 1'b0) begin failures++; $display("FAIL mid_cnvst got=%b exp=0", if_b.adc_cnvst); end
    checks++; if (if_b.adc_rst !== 1'b1) begin failures++; $display("FAIL mid_adc_rst got=%b exp=1", if_b.adc_rst); end
    checks++; if (if_b.rsp_id !== 2'd0) begin failures++; $display("FAIL mid_rsp_id got=%0d exp=0", if_b.rsp_id); end
    rst_n = 1'b1;
    step();
    checks++; if (if_b.adc_rst !== 1'b0) begin failures++; $display("FAIL mid_adc_rst_release got=%b exp=0", if_b.adc_rst); end
    seen = 0;
    repeat (60) begin
      step();
      if (if_b.rsp_valid || if_b.adc_cnvst) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_activity got=%0d exp=0", seen); end
    repeat (4) b_script.push_back(8'd50);
    if_b.req_valid = 4'b0010;
    wait_b_grant(10);
    checks++; if (if_b.req_ready !== 4'b0010) begin failures++; $display("FAIL mid_next_grant got=%b exp=0010", if_b.req_ready); end
    if_b.req_valid = 4'b0000;
    wait_b_rsp(200);
    checks++; if (if_b.rsp_id !== 2'd1) begin failures++; $display("FAIL mid_next_id got=%0d exp=1", if_b.rsp_id); end
    checks++; if (if_b.rsp_data !== 8'd50) begin failures++; $display("FAIL mid_next_data got=%0d exp=50", if_b.rsp_data); end
    checks++; if (if_b.rsp_err !== 1'b0) begin failures++; $display("FAIL mid_next_err got=%b exp=0", if_b.rsp_err); end
    accept_b();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    if_a.req_valid = '0;
    if_a.rsp_ready = 1'b0;
    if_b.req_valid = '0;
    if_b.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_average();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
